// File: rtl/eye_fatigue_judge.sv
// eye_fatigue_judge: per-frame eye open/closed judgement, PERCLOS window, closure run and fatigue alarm.
// Defining BLINK_CNT_EN adds the blink counter (blink_cnt output, blink_clr input).
module eye_fatigue_judge #(
    parameter int CLOSE_H_TH    = 3,
    parameter int RATIO_SHIFT   = 2,
    parameter int WIN_LEN       = 32,
    parameter int PERCLOS_TH    = 12,
    parameter int LONG_CLOSE_TH = 8
) (
    input  logic        module_clk,
    input  logic        module_rst,
    input  logic        frame_end,
    input  logic [10:0] eye1_up,
    input  logic [10:0] eye1_down,
    input  logic [10:0] eye1_left,
    input  logic [10:0] eye1_right,
    input  logic [10:0] eye2_up,
    input  logic [10:0] eye2_down,
    input  logic [10:0] eye2_left,
    input  logic [10:0] eye2_right,
    output logic        eye1_closed,
    output logic        eye2_closed,
    output logic [6:0]  closed_cnt,
    output logic [7:0]  close_run,
    output logic        win_full,
    output logic        fatigue_alarm,
    output logic        result_val
`ifdef BLINK_CNT_EN
    ,
    input  logic        blink_clr,
    output logic [15:0] blink_cnt
`endif
);
    localparam int FW = $clog2(WIN_LEN);
    localparam logic [10:0]   H_TH = 11'(CLOSE_H_TH);
    localparam logic [6:0]    P_TH = 7'(PERCLOS_TH);
    localparam logic [7:0]    L_TH = 8'(LONG_CLOSE_TH);
    localparam logic [FW-1:0] LAST = FW'(WIN_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_JUDGE, S_UPDATE, S_OUT} state_t;
    state_t state, state_nxt;

    logic [10:0]        h1, w1, h2, w2;
    logic               v1, v2;
    logic [WIN_LEN-1:0] win;
    logic [FW-1:0]      frm_cnt;
    logic               frame_closed, full_nxt, alarm_nxt;
    logic [6:0]         cnt_nxt;
    logic [7:0]         run_nxt;

    function automatic logic [10:0] span(input logic [10:0] lo, input logic [10:0] hi);
        return (hi > lo) ? hi - lo : 11'd0;
    endfunction

    // 13-bit compare keeps the shifted height from overflowing
    function automatic logic judge(input logic [10:0] h, input logic [10:0] w, input logic v);
        return !v || (h <= H_TH) || ((13'(h) << RATIO_SHIFT) < 13'(w));
    endfunction

    always_ff @(posedge module_clk or posedge module_rst) begin
        if (module_rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   state_nxt = frame_end ? S_CALC : S_IDLE;
            S_CALC:   state_nxt = S_JUDGE;
            S_JUDGE:  state_nxt = S_UPDATE;
            S_UPDATE: state_nxt = S_OUT;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        result_val = (state == S_OUT);
    end

    always_comb begin
        frame_closed = eye1_closed & eye2_closed;
        cnt_nxt      = closed_cnt + 7'(frame_closed) - 7'(win[WIN_LEN-1] & win_full);
        run_nxt      = frame_closed ? ((close_run == 8'hff) ? close_run : close_run + 8'd1) : 8'd0;
        full_nxt     = win_full | (frm_cnt == LAST);
        alarm_nxt    = (full_nxt && (cnt_nxt >= P_TH)) || (run_nxt >= L_TH);
    end

    // alarm is registered with the counters so it is already valid while result_val is high
    always_ff @(posedge module_clk or posedge module_rst) begin
        if (module_rst) begin
            h1            <= '0;
            w1            <= '0;
            v1            <= 1'b0;
            h2            <= '0;
            w2            <= '0;
            v2            <= 1'b0;
            eye1_closed   <= 1'b0;
            eye2_closed   <= 1'b0;
            win           <= '0;
            frm_cnt       <= '0;
            closed_cnt    <= '0;
            close_run     <= '0;
            win_full      <= 1'b0;
            fatigue_alarm <= 1'b0;
        end else begin
            if (state == S_CALC) begin
                h1 <= span(eye1_up, eye1_down);
                w1 <= span(eye1_left, eye1_right);
                v1 <= (eye1_right >= eye1_left) && (eye1_down >= eye1_up);
                h2 <= span(eye2_up, eye2_down);
                w2 <= span(eye2_left, eye2_right);
                v2 <= (eye2_right >= eye2_left) && (eye2_down >= eye2_up);
            end
            if (state == S_JUDGE) begin
                eye1_closed <= judge(h1, w1, v1);
                eye2_closed <= judge(h2, w2, v2);
            end
            if (state == S_UPDATE) begin
                win           <= {win[WIN_LEN-2:0], frame_closed};
                closed_cnt    <= cnt_nxt;
                close_run     <= run_nxt;
                win_full      <= full_nxt;
                fatigue_alarm <= alarm_nxt;
                if (!win_full)
                    frm_cnt <= frm_cnt + FW'(1);
            end
        end
    end

`ifdef BLINK_CNT_EN
    logic blink_hit;

    // a blink is a short closure that ended this frame; long closures are not blinks
    always_comb begin
        blink_hit = (state == S_UPDATE) && !frame_closed && (close_run != 8'd0) && (close_run < L_TH);
    end

    always_ff @(posedge module_clk or posedge module_rst) begin
        if (module_rst)
            blink_cnt <= '0;
        else if (blink_clr)
            blink_cnt <= '0;
        else if (blink_hit && (blink_cnt != 16'hffff))
            blink_cnt <= blink_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_eye_fatigue_judge.sv
// tb_eye_fatigue_judge: directed and randomized checks of eye_fatigue_judge against a frame-level model.
`timescale 1ns/1ps
module tb_eye_fatigue_judge;
    localparam int WIN = 32, PTH = 12, LTH = 8, HTH = 3;

    logic clk = 1'b0, rst = 1'b1, frame_end = 1'b0;
    logic [10:0] e1u, e1d, e1l, e1r, e2u, e2d, e2l, e2r;
    logic eye1_closed, eye2_closed, win_full, fatigue_alarm, result_val;
    logic [6:0] closed_cnt;
    logic [7:0] close_run;
`ifdef BLINK_CNT_EN
    logic blink_clr = 1'b0;
    logic [15:0] blink_cnt;
`endif

    int total = 0, bad = 0;
    int hist[$];
    int nframes, m_run, m_blink, x_cnt, x_run;
    logic x_e1, x_e2, x_full, x_alarm;

    eye_fatigue_judge dut (
        .module_clk(clk), .module_rst(rst), .frame_end(frame_end),
        .eye1_up(e1u), .eye1_down(e1d), .eye1_left(e1l), .eye1_right(e1r),
        .eye2_up(e2u), .eye2_down(e2d), .eye2_left(e2l), .eye2_right(e2r),
        .eye1_closed(eye1_closed), .eye2_closed(eye2_closed), .closed_cnt(closed_cnt),
        .close_run(close_run), .win_full(win_full), .fatigue_alarm(fatigue_alarm),
        .result_val(result_val)
`ifdef BLINK_CNT_EN
        , .blink_clr(blink_clr), .blink_cnt(blink_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic eye_model(int u, int d, int l, int r);
        int h = (d > u) ? d - u : 0;
        int w = (r > l) ? r - l : 0;
        return (r < l) || (d < u) || (h <= HTH) || (h * 4 < w);
    endfunction

    task automatic model_reset();
        hist.delete();
        nframes = 0; m_run = 0; m_blink = 0; x_cnt = 0; x_run = 0;
        x_e1 = 0; x_e2 = 0; x_full = 0; x_alarm = 0;
    endtask

    task automatic model_frame();
        int fc;
        x_e1 = eye_model(e1u, e1d, e1l, e1r);
        x_e2 = eye_model(e2u, e2d, e2l, e2r);
        fc = (x_e1 && x_e2) ? 1 : 0;
        if (fc == 0 && m_run >= 1 && m_run < LTH && m_blink < 65535) m_blink++;
        m_run = (fc == 1) ? ((m_run < 255) ? m_run + 1 : 255) : 0;
        hist.push_back(fc);
        if (hist.size() > WIN) void'(hist.pop_front());
        nframes++;
        x_cnt = 0;
        foreach (hist[i]) x_cnt += hist[i];
        x_full = (nframes >= WIN);
        x_run = m_run;
        x_alarm = (x_full && x_cnt >= PTH) || (m_run >= LTH);
    endtask

    task automatic set_eye(input int n, input int u, input int d, input int l, input int r);
        if (n == 1) begin e1u = 11'(u); e1d = 11'(d); e1l = 11'(l); e1r = 11'(r); end
        else begin e2u = 11'(u); e2d = 11'(d); e2l = 11'(l); e2r = 11'(r); end
    endtask

    task automatic set_both(input int closed);
        set_eye(1, 200, closed ? 202 : 212, 100, 130);
        set_eye(2, 200, closed ? 202 : 212, 300, 330);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; frame_end = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // lat = number of negedges after frame_end is raised until result_val is seen (-1 on timeout)
    task automatic run_frame(output int lat);
        @(negedge clk);
        frame_end = 1'b1;
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            frame_end = 1'b0;
            if (result_val) begin lat = i; break; end
        end
        model_frame();
    endtask

    task automatic test_reset();
        int pulses = 0;
        rst = 1'b1; frame_end = 1'b0;
        set_both(0);
        repeat (3) begin @(negedge clk); pulses += int'(result_val); end
        rst = 1'b0;
        repeat (10) begin @(negedge clk); pulses += int'(result_val); end
        total++; if (pulses != 0) begin bad++; $display("FAIL reset result_val pulses: got %0d want 0", pulses); end
        total++; if ({eye1_closed, eye2_closed, win_full, fatigue_alarm} !== 4'b0) begin bad++; $display("FAIL reset flags: got %b want 0000", {eye1_closed, eye2_closed, win_full, fatigue_alarm}); end
        total++; if (closed_cnt !== 7'd0) begin bad++; $display("FAIL reset closed_cnt: got %0d want 0", closed_cnt); end
        total++; if (close_run !== 8'd0) begin bad++; $display("FAIL reset close_run: got %0d want 0", close_run); end
        model_reset();
    endtask

    task automatic test_open_frame();
        int lat;
        do_reset();
        set_both(0);
        run_frame(lat);
        total++; if (lat != 4) begin bad++; $display("FAIL open latency: got %0d want 4", lat); end
        total++; if ({eye1_closed, eye2_closed} !== 2'b00) begin bad++; $display("FAIL open eyes: got %b want 00", {eye1_closed, eye2_closed}); end
        total++; if (closed_cnt !== 7'd0) begin bad++; $display("FAIL open closed_cnt: got %0d want 0", closed_cnt); end
        total++; if (close_run !== 8'd0) begin bad++; $display("FAIL open close_run: got %0d want 0", close_run); end
    endtask

    task automatic test_sustained();
        int lat;
        do_reset();
        set_both(1);
        for (int i = 1; i <= 8; i++) begin
            run_frame(lat);
            total++; if (lat != 4) begin bad++; $display("FAIL sustained latency f%0d: got %0d want 4", i, lat); end
            total++; if (close_run !== 8'(i)) begin bad++; $display("FAIL sustained close_run f%0d: got %0d want %0d", i, close_run, i); end
            total++; if (fatigue_alarm !== (i >= LTH)) begin bad++; $display("FAIL sustained alarm f%0d: got %b want %b", i, fatigue_alarm, i >= LTH); end
            total++; if (win_full !== 1'b0) begin bad++; $display("FAIL sustained win_full f%0d: got %b want 0", i, win_full); end
        end
        set_both(0);
        run_frame(lat);
        total++; if (close_run !== 8'd0) begin bad++; $display("FAIL sustained reopen close_run: got %0d want 0", close_run); end
        total++; if (fatigue_alarm !== 1'b0) begin bad++; $display("FAIL sustained reopen alarm: got %b want 0", fatigue_alarm); end
    endtask

    task automatic test_perclos();
        int lat;
        do_reset();
        for (int f = 0; f < 32; f++) begin
            set_both((f % 8) < 3);
            run_frame(lat);
            total++; if (win_full !== (f == 31)) begin bad++; $display("FAIL perclos win_full f%0d: got %b want %b", f + 1, win_full, f == 31); end
        end
        total++; if (closed_cnt !== 7'd12) begin bad++; $display("FAIL perclos full closed_cnt: got %0d want 12", closed_cnt); end
        total++; if (fatigue_alarm !== 1'b1) begin bad++; $display("FAIL perclos full alarm: got %b want 1", fatigue_alarm); end
        set_both(0);
        repeat (8) run_frame(lat);
        total++; if (closed_cnt !== 7'd9) begin bad++; $display("FAIL perclos slide closed_cnt: got %0d want 9", closed_cnt); end
        total++; if (fatigue_alarm !== 1'b0) begin bad++; $display("FAIL perclos slide alarm: got %b want 0", fatigue_alarm); end
        total++; if (win_full !== 1'b1) begin bad++; $display("FAIL perclos slide win_full: got %b want 1", win_full); end
    endtask

    task automatic test_ratio_empty();
        int lat;
        do_reset();
        set_eye(1, 200, 206, 100, 130);
        set_eye(2, 200, 212, 300, 330);
        run_frame(lat);
        total++; if ({eye1_closed, eye2_closed} !== 2'b10) begin bad++; $display("FAIL ratio eyes: got %b want 10", {eye1_closed, eye2_closed}); end
        total++; if (closed_cnt !== 7'd0) begin bad++; $display("FAIL ratio closed_cnt: got %0d want 0", closed_cnt); end
        set_eye(1, 200, 208, 100, 132);
        run_frame(lat);
        total++; if (eye1_closed !== 1'b0) begin bad++; $display("FAIL ratio edge eye1 (32<32): got %b want 0", eye1_closed); end
        set_eye(1, 200, 202, 100, 130);
        set_eye(2, 0, 0, 640, 0);
        run_frame(lat);
        total++; if ({eye1_closed, eye2_closed} !== 2'b11) begin bad++; $display("FAIL empty eyes: got %b want 11", {eye1_closed, eye2_closed}); end
        total++; if (closed_cnt !== 7'd1) begin bad++; $display("FAIL empty closed_cnt: got %0d want 1", closed_cnt); end
        total++; if (close_run !== 8'd1) begin bad++; $display("FAIL empty close_run: got %0d want 1", close_run); end
    endtask

    task automatic test_ignore_refire();
        int pulses = 0, first = -1;
        do_reset();
        set_both(1);
        @(negedge clk);
        frame_end = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            frame_end = (i == 2);
            if (result_val) begin pulses++; if (first < 0) first = i; end
        end
        model_frame();
        total++; if (pulses != 1) begin bad++; $display("FAIL refire pulses: got %0d want 1", pulses); end
        total++; if (first != 4) begin bad++; $display("FAIL refire latency: got %0d want 4", first); end
        total++; if (closed_cnt !== 7'(x_cnt)) begin bad++; $display("FAIL refire closed_cnt: got %0d want %0d", closed_cnt, x_cnt); end
    endtask

    task automatic test_reset_abort();
        int lat, pulses = 0;
        do_reset();
        set_both(1);
        repeat (3) run_frame(lat);
        @(negedge clk);
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (8) begin @(negedge clk); pulses += int'(result_val); end
        total++; if (pulses != 0) begin bad++; $display("FAIL abort pulses: got %0d want 0", pulses); end
        total++; if ({closed_cnt, close_run, eye1_closed, eye2_closed} !== 17'd0) begin bad++; $display("FAIL abort state: cnt=%0d run=%0d eyes=%b want all 0", closed_cnt, close_run, {eye1_closed, eye2_closed}); end
    endtask

`ifdef BLINK_CNT_EN
    task automatic test_blink();
        int lat;
        do_reset();
        set_both(1);
        repeat (2) run_frame(lat);
        set_both(0);
        run_frame(lat);
        total++; if (blink_cnt !== 16'd1) begin bad++; $display("FAIL blink short: got %0d want 1", blink_cnt); end
        set_both(1);
        repeat (10) run_frame(lat);
        set_both(0);
        run_frame(lat);
        total++; if (blink_cnt !== 16'd1) begin bad++; $display("FAIL blink long: got %0d want 1", blink_cnt); end
        @(negedge clk);
        blink_clr = 1'b1;
        @(negedge clk);
        blink_clr = 1'b0;
        m_blink = 0;
        total++; if (blink_cnt !== 16'd0) begin bad++; $display("FAIL blink clr: got %0d want 0", blink_cnt); end
    endtask
`endif

    task automatic rand_eye(input int n, input int bias);
        int u, h, l, w, k;
        u = int'($urandom_range(900, 10));
        l = int'($urandom_range(900, 10));
        k = (int'($urandom_range(99, 0)) < bias) ? int'($urandom_range(3, 0)) : 4;
        case (k)
            0: begin h = int'($urandom_range(3, 0)); w = int'($urandom_range(60, 0)); set_eye(n, u, u + h, l, l + w); end
            1: begin h = int'($urandom_range(15, 4)); w = 4 * h + int'($urandom_range(20, 1)); set_eye(n, u, u + h, l, l + w); end
            2: set_eye(n, 0, 0, 640, 0);
            3: if ($urandom_range(1, 0) == 1) set_eye(n, u, u - int'($urandom_range(5, 1)), l, l + 20);
               else set_eye(n, u, u + 20, l, l - int'($urandom_range(5, 1)));
            default: begin h = int'($urandom_range(60, 4)); w = int'($urandom_range(4 * h, 0)); set_eye(n, u, u + h, l, l + w); end
        endcase
    endtask

    task automatic test_random();
        int lat, bias;
        do_reset();
        for (int f = 0; f < 300; f++) begin
            bias = ((f / 40) % 3 == 0) ? 20 : ((f / 40) % 3 == 1) ? 70 : 97;
            rand_eye(1, bias);
            rand_eye(2, bias);
            run_frame(lat);
            total++; if (lat != 4) begin bad++; $display("FAIL rnd latency f%0d: got %0d want 4", f, lat); end
            total++; if ({eye1_closed, eye2_closed} !== {x_e1, x_e2}) begin bad++; $display("FAIL rnd eyes f%0d: got %b want %b", f, {eye1_closed, eye2_closed}, {x_e1, x_e2}); end
            total++; if (closed_cnt !== 7'(x_cnt)) begin bad++; $display("FAIL rnd closed_cnt f%0d: got %0d want %0d", f, closed_cnt, x_cnt); end
            total++; if (close_run !== 8'(x_run)) begin bad++; $display("FAIL rnd close_run f%0d: got %0d want %0d", f, close_run, x_run); end
            total++; if (win_full !== x_full) begin bad++; $display("FAIL rnd win_full f%0d: got %b want %b", f, win_full, x_full); end
            total++; if (fatigue_alarm !== x_alarm) begin bad++; $display("FAIL rnd alarm f%0d: got %b want %b", f, fatigue_alarm, x_alarm); end
`ifdef BLINK_CNT_EN
            total++; if (blink_cnt !== 16'(m_blink)) begin bad++; $display("FAIL rnd blink_cnt f%0d: got %0d want %0d", f, blink_cnt, m_blink); end
`endif
        end
    endtask

    initial begin
        set_both(0);
        model_reset();
        test_reset();
        test_open_frame();
        test_sustained();
        test_perclos();
        test_ratio_empty();
        test_ignore_refire();
        test_reset_abort();
`ifdef BLINK_CNT_EN
        test_blink();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
